// File: rtl/aes_block_sequencer_pkg.sv
// Shared state encoding and constants for the AES block sequencer.
package aes_package;

    typedef enum logic [3:0] {
        IDLE,
        ERR,
        KEY_INIT,
        KEY_WAIT,
        LOAD_REQ,
        LOAD_WAIT,
        CORE_START,
        CORE_WAIT,
        STORE_REQ,
        STORE_WAIT,
        NEXT_BLK,
        DONE
    } aes_seq_state_t;

    localparam int unsigned AES_BLOCK_BYTES = 16;

    // Index width that stays legal for single-word blocks.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_block_sequencer_if.sv
// Streamer and AES-core handshake bundle driven by the block sequencer.
interface aes_block_sequencer_if #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned WORD_W          = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4
);
    localparam int unsigned IDX_W       = aes_package::idx_width(WORDS_PER_BLOCK);
    localparam int unsigned BLOCK_BYTES = WORDS_PER_BLOCK * WORD_W / 8;

    logic                   src_req_start_o;
    logic                   src_ready_start_i;
    logic                   src_done_i;
    logic [ADDR_W-1:0]      src_addr_o;

    logic                   snk_req_start_o;
    logic                   snk_ready_start_i;
    logic                   snk_done_i;
    logic [ADDR_W-1:0]      snk_addr_o;

    logic                   core_init_key_o;
    logic                   core_key_ready_i;
    logic                   core_start_o;
    logic                   core_valid_i;
    logic                   chain_o;
    logic [IDX_W-1:0]       word_idx_o;
    logic [BLOCK_BYTES-1:0] pad_mask_o;

    modport master (
        output src_req_start_o, src_addr_o,
        output snk_req_start_o, snk_addr_o,
        output core_init_key_o, core_start_o, chain_o, word_idx_o, pad_mask_o,
        input  src_ready_start_i, src_done_i,
        input  snk_ready_start_i, snk_done_i,
        input  core_key_ready_i, core_valid_i
    );

    modport slave (
        input  src_req_start_o, src_addr_o,
        input  snk_req_start_o, snk_addr_o,
        input  core_init_key_o, core_start_o, chain_o, word_idx_o, pad_mask_o,
        output src_ready_start_i, src_done_i,
        output snk_ready_start_i, snk_done_i,
        output core_key_ready_i, core_valid_i
    );

endinterface

// File: rtl/aes_seq_addr_gen.sv
// Block/word counters plus streamer addresses and byte-valid mask for the current block.
module aes_seq_addr_gen
    import aes_package::*;
#(
    parameter int unsigned WORD_W          = 32,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned LEN_W           = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    localparam int unsigned BLOCK_BYTES    = WORDS_PER_BLOCK * WORD_W / 8,
    localparam int unsigned IDX_W          = idx_width(WORDS_PER_BLOCK),
    localparam int unsigned CNT_W          = LEN_W + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   cnt_clr,
    input  logic                   word_inc,
    input  logic                   blk_inc,
    input  logic                   active,
    input  logic [ADDR_W-1:0]      in_base,
    input  logic [ADDR_W-1:0]      out_base,
    input  logic [LEN_W-1:0]       byte_len,
    output logic [CNT_W-1:0]       blk,
    output logic [IDX_W-1:0]       word,
    output logic                   last_word,
    output logic                   word_valid,
    output logic [ADDR_W-1:0]      src_addr,
    output logic [ADDR_W-1:0]      snk_addr,
    output logic [BLOCK_BYTES-1:0] pad_mask
);

    localparam logic [ADDR_W-1:0] BLOCK_STEP = ADDR_W'(BLOCK_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_W / 8);

    logic [ADDR_W-1:0] offset;
    logic [CNT_W-1:0]  len_ext;
    logic [CNT_W-1:0]  blk_off;
    logic [CNT_W-1:0]  remaining;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk  <= '0;
            word <= '0;
        end else if (clear || cnt_clr) begin
            blk  <= '0;
            word <= '0;
        end else if (blk_inc) begin
            blk  <= blk + 1'b1;
            word <= '0;
        end else if (word_inc) begin
            word <= last_word ? '0 : word + 1'b1;
        end
    end

    assign last_word = (word == IDX_W'(WORDS_PER_BLOCK - 1));

    // Address arithmetic is ADDR_W wide so a job crossing the top of memory wraps.
    assign offset   = ADDR_W'(blk) * BLOCK_STEP + ADDR_W'(word) * WORD_STEP;
    assign src_addr = in_base + offset;
    assign snk_addr = out_base + offset;

    assign len_ext   = CNT_W'(byte_len);
    assign blk_off   = blk * CNT_W'(BLOCK_BYTES);
    assign remaining = (len_ext > blk_off) ? (len_ext - blk_off) : '0;

    assign word_valid = (CNT_W'(word) * CNT_W'(WORD_W / 8)) < remaining;

    // Outside a job the mask reads all ones so idle consumers see a full block.
    always_comb begin
        pad_mask = '1;
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
            pad_mask[i] = !active || (CNT_W'(i) < remaining);
        end
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// Job sequencer for the AES HWPE: key expansion, per-block word load, core run and word store.
module aes_block_sequencer
    import aes_package::*;
#(
    parameter int unsigned WORD_W          = 32,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned LEN_W           = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    localparam int unsigned BLOCK_BYTES    = WORDS_PER_BLOCK * WORD_W / 8,
    localparam int unsigned IDX_W          = idx_width(WORDS_PER_BLOCK),
    localparam int unsigned CNT_W          = LEN_W + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 start_i,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 err_o,
    input  logic [ADDR_W-1:0]    in_base_i,
    input  logic [ADDR_W-1:0]    out_base_i,
    input  logic [LEN_W-1:0]     byte_len_i,
    input  logic                 cbc_en_i,
    input  logic                 key_update_i,
    aes_block_sequencer_if.master bus
);

    aes_seq_state_t state;
    aes_seq_state_t state_nxt;

    logic                   key_loaded;
    logic [ADDR_W-1:0]      in_base_q;
    logic [ADDR_W-1:0]      out_base_q;
    logic [LEN_W-1:0]       byte_len_q;
    logic                   cbc_en_q;
    logic [CNT_W-1:0]       nblk_q;

    logic                   cnt_clr;
    logic                   word_inc;
    logic                   blk_inc;
    logic [CNT_W-1:0]       blk;
    logic [IDX_W-1:0]       word;
    logic                   last_word;
    logic                   word_valid;
    logic [ADDR_W-1:0]      src_addr;
    logic [ADDR_W-1:0]      snk_addr;
    logic [BLOCK_BYTES-1:0] pad_mask;

    aes_seq_addr_gen #(
        .WORD_W          (WORD_W),
        .ADDR_W          (ADDR_W),
        .LEN_W           (LEN_W),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .cnt_clr    (cnt_clr),
        .word_inc   (word_inc),
        .blk_inc    (blk_inc),
        .active     (busy_o),
        .in_base    (in_base_q),
        .out_base   (out_base_q),
        .byte_len   (byte_len_q),
        .blk        (blk),
        .word       (word),
        .last_word  (last_word),
        .word_valid (word_valid),
        .src_addr   (src_addr),
        .snk_addr   (snk_addr),
        .pad_mask   (pad_mask)
    );

    assign cnt_clr = (state == IDLE) && start_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            key_loaded <= 1'b0;
            in_base_q  <= '0;
            out_base_q <= '0;
            byte_len_q <= '0;
            cbc_en_q   <= 1'b0;
            nblk_q     <= '0;
        end else if (clear) begin
            state      <= IDLE;
            key_loaded <= 1'b0;
            in_base_q  <= '0;
            out_base_q <= '0;
            byte_len_q <= '0;
            cbc_en_q   <= 1'b0;
            nblk_q     <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr) begin
                in_base_q  <= in_base_i;
                out_base_q <= out_base_i;
                byte_len_q <= byte_len_i;
                cbc_en_q   <= cbc_en_i;
                nblk_q     <= (CNT_W'(byte_len_i) + CNT_W'(BLOCK_BYTES - 1)) / CNT_W'(BLOCK_BYTES);
            end
            if (state == KEY_WAIT && bus.core_key_ready_i) begin
                key_loaded <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        word_inc  = 1'b0;
        blk_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (byte_len_i == '0) begin
                        state_nxt = ERR;
                    end else if (key_update_i || !key_loaded) begin
                        state_nxt = KEY_INIT;
                    end else begin
                        state_nxt = LOAD_REQ;
                    end
                end
            end
            ERR:      state_nxt = IDLE;
            KEY_INIT: state_nxt = KEY_WAIT;
            KEY_WAIT: if (bus.core_key_ready_i) state_nxt = LOAD_REQ;
            LOAD_REQ: begin
                // Padding words are counted here without a fetch; src_done is never looked at.
                if (!word_valid) begin
                    word_inc  = 1'b1;
                    state_nxt = last_word ? CORE_START : LOAD_REQ;
                end else if (bus.src_ready_start_i) begin
                    state_nxt = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (bus.src_done_i) begin
                    word_inc  = 1'b1;
                    state_nxt = last_word ? CORE_START : LOAD_REQ;
                end
            end
            CORE_START: state_nxt = CORE_WAIT;
            CORE_WAIT:  if (bus.core_valid_i) state_nxt = STORE_REQ;
            STORE_REQ:  if (bus.snk_ready_start_i) state_nxt = STORE_WAIT;
            STORE_WAIT: begin
                if (bus.snk_done_i) begin
                    word_inc  = 1'b1;
                    state_nxt = last_word ? NEXT_BLK : STORE_REQ;
                end
            end
            NEXT_BLK: begin
                blk_inc   = 1'b1;
                state_nxt = ((blk + 1'b1) == nblk_q) ? DONE : LOAD_REQ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o              = (state != IDLE);
        done_o              = (state == DONE);
        err_o               = (state == ERR);
        bus.src_req_start_o = (state == LOAD_REQ) && word_valid;
        bus.snk_req_start_o = (state == STORE_REQ);
        bus.src_addr_o      = src_addr;
        bus.snk_addr_o      = snk_addr;
        bus.core_init_key_o = (state == KEY_INIT);
        bus.core_start_o    = (state == CORE_START);
        bus.chain_o         = cbc_en_q && (blk != '0) &&
                              (state inside {LOAD_REQ, LOAD_WAIT, CORE_START, CORE_WAIT});
        bus.word_idx_o      = word;
        bus.pad_mask_o      = pad_mask;
    end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench: job table plus hand sequences for clear and async reset mid-job.
module tb_aes_block_sequencer;

    localparam int unsigned BB       = aes_package::AES_BLOCK_BYTES;
    localparam int          CORE_LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        start_i = 1'b0;
    logic        done_o, busy_o, err_o;
    logic [31:0] in_base_i = '0;
    logic [31:0] out_base_i = '0;
    logic [31:0] byte_len_i = '0;
    logic        cbc_en_i = 1'b0;
    logic        key_update_i = 1'b0;

    aes_block_sequencer_if #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_BLOCK(4)) bus ();

    aes_block_sequencer #(
        .WORD_W          (32),
        .ADDR_W          (32),
        .LEN_W           (32),
        .WORDS_PER_BLOCK (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .start_i      (start_i),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .in_base_i    (in_base_i),
        .out_base_i   (out_base_i),
        .byte_len_i   (byte_len_i),
        .cbc_en_i     (cbc_en_i),
        .key_update_i (key_update_i),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Streamer and core responders: accept requests at once, complete one cycle later.
    logic src_pend = 1'b0, snk_pend = 1'b0, key_pend = 1'b0;
    int   core_cnt = 0;
    always @(negedge clk) begin
        bus.src_done_i        = src_pend;
        src_pend              = bus.src_req_start_o;
        bus.src_ready_start_i = bus.src_req_start_o;
        bus.snk_done_i        = snk_pend;
        snk_pend              = bus.snk_req_start_o;
        bus.snk_ready_start_i = bus.snk_req_start_o;
        bus.core_key_ready_i  = key_pend;
        key_pend              = bus.core_init_key_o;
        if (bus.core_start_o) begin
            bus.core_valid_i = 1'b0;
            core_cnt         = CORE_LAT;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) bus.core_valid_i = 1'b1;
        end
    end

    int          n_src, n_snk, n_core, n_key, n_done, n_err, n_busy;
    logic [31:0] first_src, src4, last_src, last_snk;
    logic [7:0]  chain_bits;
    logic [BB-1:0] last_pad;

    always @(negedge clk) begin
        if (bus.src_req_start_o) begin
            if (n_src == 0) first_src = bus.src_addr_o;
            if (n_src == 4) src4 = bus.src_addr_o;
            last_src = bus.src_addr_o;
            n_src++;
        end
        if (bus.snk_req_start_o) begin
            last_snk = bus.snk_addr_o;
            n_snk++;
        end
        if (bus.core_start_o) begin
            if (n_core < 8) chain_bits[n_core] = bus.chain_o;
            last_pad = bus.pad_mask_o;
            n_core++;
        end
        if (bus.core_init_key_o) n_key++;
        if (done_o) n_done++;
        if (err_o) n_err++;
        if (busy_o) n_busy++;
    end

    task automatic mon_clear();
        n_src = 0; n_snk = 0; n_core = 0; n_key = 0; n_done = 0; n_err = 0; n_busy = 0;
        first_src = '0; src4 = '0; last_src = '0; last_snk = '0;
        chain_bits = '0; last_pad = '0;
    endtask

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] len, input logic [31:0] ib, input logic [31:0] ob,
                             input logic cbc, input logic ku);
        @(negedge clk);
        byte_len_i = len; in_base_i = ib; out_base_i = ob;
        cbc_en_i = cbc; key_update_i = ku; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] len, input logic [31:0] ib, input logic [31:0] ob,
                           input logic cbc, input logic ku, input string tag);
        bit finished;
        mon_clear();
        start_job(len, ib, ob, cbc, ku);
        finished = 1'b0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (!busy_o) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_finished"}, 32'(finished), 32'd1);
    endtask

    typedef struct {
        logic [31:0] len, ib, ob;
        logic        cbc, ku;
        int          e_src, e_snk, e_core, e_key, e_done, e_err;
        logic [31:0] e_first_src, e_src4, e_last_src, e_last_snk;
        logic [7:0]  e_chain;
        logic [15:0] e_pad;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'd32, 32'h1000, 32'h2000, 1'b0, 1'b1, 8, 8, 2, 1, 1, 0,
                    32'h1000, 32'h1010, 32'h101C, 32'h201C, 8'h00, 16'hFFFF};
        vecs[1] = '{32'd20, 32'h3000, 32'h4000, 1'b0, 1'b0, 5, 8, 2, 0, 1, 0,
                    32'h3000, 32'h3010, 32'h3010, 32'h401C, 8'h00, 16'h000F};
        vecs[2] = '{32'd0, 32'h7000, 32'h7800, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1,
                    32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 16'h0000};
        vecs[3] = '{32'd48, 32'h0100, 32'h0200, 1'b1, 1'b0, 12, 12, 3, 0, 1, 0,
                    32'h0100, 32'h0110, 32'h012C, 32'h022C, 8'h06, 16'hFFFF};
        vecs[4] = '{32'd32, 32'hFFFF_FFF0, 32'h8000, 1'b0, 1'b1, 8, 8, 2, 1, 1, 0,
                    32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_000C, 32'h801C, 8'h00, 16'hFFFF};
        vecs[5] = '{32'd1, 32'h0500, 32'h0600, 1'b0, 1'b0, 1, 4, 1, 0, 1, 0,
                    32'h0500, 32'h0, 32'h0500, 32'h060C, 8'h00, 16'h0001};

        mon_clear();
        repeat (3) @(negedge clk);
        #1;
        check("rst_status", {29'd0, done_o, busy_o, err_o}, 32'd0);
        check("rst_ctrl", {27'd0, bus.src_req_start_o, bus.snk_req_start_o, bus.core_init_key_o,
                           bus.core_start_o, bus.chain_o}, 32'd0);
        check("rst_addr", bus.src_addr_o | bus.snk_addr_o | 32'(bus.word_idx_o), 32'd0);
        check("rst_pad", 32'(bus.pad_mask_o), 32'h0000_FFFF);
        #3 reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].len, vecs[i].ib, vecs[i].ob, vecs[i].cbc, vecs[i].ku, $sformatf("v%0d", i));
            check($sformatf("v%0d_src_fetches", i), n_src, vecs[i].e_src);
            check($sformatf("v%0d_snk_stores", i), n_snk, vecs[i].e_snk);
            check($sformatf("v%0d_core_starts", i), n_core, vecs[i].e_core);
            check($sformatf("v%0d_key_inits", i), n_key, vecs[i].e_key);
            check($sformatf("v%0d_done_pulses", i), n_done, vecs[i].e_done);
            check($sformatf("v%0d_err_pulses", i), n_err, vecs[i].e_err);
            check($sformatf("v%0d_first_src", i), first_src, vecs[i].e_first_src);
            check($sformatf("v%0d_src_blk1", i), src4, vecs[i].e_src4);
            check($sformatf("v%0d_last_src", i), last_src, vecs[i].e_last_src);
            check($sformatf("v%0d_last_snk", i), last_snk, vecs[i].e_last_snk);
            check($sformatf("v%0d_chain", i), 32'(chain_bits), 32'(vecs[i].e_chain));
            check($sformatf("v%0d_pad_mask", i), 32'(last_pad), 32'(vecs[i].e_pad));
            if (vecs[i].e_err != 0) check($sformatf("v%0d_err_busy_cycles", i), n_busy, 32'd1);
        end

        // Clear while the core is running: job dropped, key must be re-expanded.
        mon_clear();
        start_job(32'd32, 32'h1000, 32'h2000, 1'b0, 1'b0);
        for (int i = 0; i < 100 && n_core == 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("clr_core_reached", n_core, 32'd1);
        check("clr_no_key_init", n_key, 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr_busy_next", 32'(busy_o), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        check("clr_no_done", n_done, 32'd0);
        check("clr_no_store", n_snk, 32'd0);
        run_job(32'd16, 32'h1000, 32'h2000, 1'b0, 1'b0, "clr_rerun");
        check("clr_rerun_key_init", n_key, 32'd1);
        check("clr_rerun_done", n_done, 32'd1);
        check("clr_rerun_fetches", n_src, 32'd4);

        // Asynchronous reset mid-job, released away from the clock edge.
        mon_clear();
        start_job(32'd48, 32'h5000, 32'h6000, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_ctrl", {28'd0, bus.src_req_start_o, bus.snk_req_start_o,
                            bus.core_start_o, bus.chain_o}, 32'd0);
        check("arst_pad", 32'(bus.pad_mask_o), 32'h0000_FFFF);
        @(negedge clk);
        #2 reset_n = 1'b1;
        mon_clear();
        repeat (12) @(negedge clk);
        #1;
        check("arst_no_pulses", n_src + n_snk + n_core + n_key + n_done + n_err, 32'd0);
        check("arst_idle", n_busy, 32'd0);
        run_job(32'd16, 32'h1000, 32'h2000, 1'b0, 1'b0, "arst_rerun");
        check("arst_rerun_key_init", n_key, 32'd1);
        check("arst_rerun_done", n_done, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
